// File: rtl/mf_pkg.sv
// Shared constants, FSM state type and output scaling helper for the
// accumulating dot-product blocks.
package mf_pkg;

  localparam int unsigned MF_W     = 32;
  localparam int unsigned MF_ACC_W = 72;
  localparam int unsigned MF_SHIFT = 35;
  localparam int unsigned MF_OUT_W = 32;
  // Working width for scaling; must cover the widest accumulator in use.
  localparam int unsigned MF_XW    = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } mf_state_e;

  // Bits needed to hold an n-lane sum of w x w signed products.
  function automatic int unsigned mf_sum_w(input int unsigned n, input int unsigned w);
    return 2 * w + $clog2(n);
  endfunction

  // Returns {ovf, t}: t = acc >>> shift, clamped to out_w signed range when
  // sat_en is set; the caller keeps the low out_w bits of t.
  function automatic logic [MF_XW:0] sat_trunc(
    input logic signed [MF_XW-1:0] acc,
    input logic                    sat_en,
    input int unsigned             shift,
    input int unsigned             out_w
  );
    logic signed [MF_XW-1:0] t;
    logic signed [MF_XW-1:0] hi;
    logic signed [MF_XW-1:0] lo;
    t  = acc >>> shift;
    hi = signed'((MF_XW'(1) << (out_w - 1)) - MF_XW'(1));
    lo = ~hi;
    if (sat_en && (t > hi)) return {1'b1, hi};
    if (sat_en && (t < lo)) return {1'b1, lo};
    return {1'b0, t};
  endfunction

endpackage

// File: rtl/mf_scale_sat.sv
// Output stage: arithmetic shift, saturate or truncate, and register the
// result with a one-cycle valid pulse.
module mf_scale_sat
  import mf_pkg::*;
#(
  parameter int unsigned ACC_W = MF_ACC_W,
  parameter int unsigned SHIFT = MF_SHIFT,
  parameter int unsigned OUT_W = MF_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic             i_sat_en,
  input  logic [ACC_W-1:0] i_acc,
  output logic             o_pushout,
  output logic [OUT_W-1:0] o_res,
  output logic             o_ovf
);

  logic signed [MF_XW-1:0]  w_acc_ext;
  logic                     w_ovf;
  logic [MF_XW-OUT_W-1:0]   w_unused_hi;
  logic [OUT_W-1:0]         w_res;

  always_comb begin
    w_acc_ext = MF_XW'(signed'(i_acc));
    {w_ovf, w_unused_hi, w_res} = sat_trunc(w_acc_ext, i_sat_en, SHIFT, OUT_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_pushout <= 1'b0;
      o_res     <= '0;
      o_ovf     <= 1'b0;
    end else begin
      o_pushout <= i_valid;
      if (i_valid) begin
        o_res <= w_res;
        o_ovf <= w_ovf;
      end
    end
  end

endmodule

// File: rtl/mf_acc.sv
// N-lane signed dot-product MAC that accumulates beats until lastin, then
// emits one shifted and saturated/truncated result per vector.
module mf_acc
  import mf_pkg::*;
#(
  parameter int unsigned N     = 20,
  parameter int unsigned W     = MF_W,
  parameter int unsigned ACC_W = MF_ACC_W,
  parameter int unsigned SHIFT = MF_SHIFT,
  parameter int unsigned OUT_W = MF_OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pushin,
  input  logic             lastin,
  input  logic             sat_en,
  input  logic [N*W-1:0]   din,
  input  logic [N*W-1:0]   win,
  output logic             pushout,
  output logic [OUT_W-1:0] res,
  output logic             ovf
);

  localparam int unsigned SUM_W = mf_sum_w(N, W);

  // S1
  logic [N*W-1:0] r1_din, r1_win;
  logic           r1_vld, r1_last, r1_sat;
  // S2
  logic signed [2*W-1:0] w_prod [N];
  logic signed [2*W-1:0] r2_prod [N];
  logic                  r2_vld, r2_last, r2_sat;
  // S3
  logic signed [SUM_W-1:0] w_sum;
  logic [ACC_W-1:0]        r3_sum;
  logic                    r3_vld, r3_last, r3_sat;
  // S4
  mf_state_e        r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r4_emit, r4_sat;

  for (genvar i = 0; i < N; i++) begin : g_mul
    assign w_prod[i] = (2*W)'(signed'(r1_din[i*W +: W])) * (2*W)'(signed'(r1_win[i*W +: W]));
  end

  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < N; i++) w_sum = w_sum + SUM_W'(r2_prod[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_din  <= '0;
      r1_win  <= '0;
      r1_vld  <= 1'b0;
      r1_last <= 1'b0;
      r1_sat  <= 1'b0;
      for (int unsigned i = 0; i < N; i++) r2_prod[i] <= '0;
      r2_vld  <= 1'b0;
      r2_last <= 1'b0;
      r2_sat  <= 1'b0;
      r3_sum  <= '0;
      r3_vld  <= 1'b0;
      r3_last <= 1'b0;
      r3_sat  <= 1'b0;
    end else begin
      r1_din  <= din;
      r1_win  <= win;
      r1_vld  <= pushin;
      r1_last <= pushin & lastin;
      r1_sat  <= sat_en;
      for (int unsigned i = 0; i < N; i++) r2_prod[i] <= w_prod[i];
      r2_vld  <= r1_vld;
      r2_last <= r1_last;
      r2_sat  <= r1_sat;
      r3_sum  <= ACC_W'(w_sum);
      r3_vld  <= r2_vld;
      r3_last <= r2_last;
      r3_sat  <= r2_sat;
    end
  end

  // Accumulator FSM: only valid beats advance it; bubbles hold everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r4_emit <= 1'b0;
      r4_sat  <= 1'b0;
    end else begin
      r4_emit <= r3_vld & r3_last;
      if (r3_vld) begin
        r_acc   <= (r_state == IDLE) ? r3_sum : r_acc + r3_sum;
        r_state <= r3_last ? IDLE : ACCUM;
        if (r3_last) r4_sat <= r3_sat;
      end
    end
  end

  mf_scale_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_scale (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (r4_emit),
    .i_sat_en  (r4_sat),
    .i_acc     (r_acc),
    .o_pushout (pushout),
    .o_res     (res),
    .o_ovf     (ovf)
  );

endmodule
